// File: rtl/mines_core_param.sv
// Parametrised minesweeper board engine: LCG mine placement, valid/ready cell selection, scoring.
// Optional feature macro FLAG_EN adds in_sel_flag / out_flags so a selection can toggle a flag.
module mines_core_param #(
    parameter int GRID_W  = 5,
    parameter int GRID_H  = 5,
    parameter int N_MINES = 3,
    parameter int SEED_W  = 8,
    parameter int SCORE_W = 32,
    localparam int CELLS  = GRID_W * GRID_H,
    localparam int IDX_W  = $clog2(CELLS)
) (
    input  logic               in_clka,
    input  logic               in_restart_n,
    input  logic               in_start,
    input  logic [SEED_W-1:0]  in_seed,
    input  logic [SEED_W-1:0]  in_mult,
    input  logic [SEED_W-1:0]  in_increment,
    input  logic               in_sel_valid,
    input  logic [IDX_W-1:0]   in_sel_idx,
`ifdef FLAG_EN
    input  logic               in_sel_flag,
    output logic [CELLS-1:0]   out_flags,
`endif
    output logic               out_sel_ready,
    output logic [2:0]         out_state,
    output logic [CELLS-1:0]   out_mines,
    output logic [CELLS-1:0]   out_cleared,
    output logic [3:0]         out_n_nearby,
    output logic               out_result_valid,
    output logic [SCORE_W-1:0] out_score,
    output logic               out_gameover,
    output logic               out_win
);
    localparam int CNT_W = $clog2(N_MINES + 1);

    if (N_MINES < 1 || N_MINES >= CELLS) begin : g_bad_n_mines
        $error("mines_core_param: N_MINES must satisfy 1 <= N_MINES < CELLS");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLACE = 3'd1,
        S_WAIT  = 3'd2,
        S_EVAL  = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t             state_r;
    logic [SEED_W-1:0]  lcg_r;
    logic [CNT_W-1:0]   count_r;
    logic [IDX_W-1:0]   sel_idx_r;
`ifdef FLAG_EN
    logic               sel_flag_r;
`endif

    logic [SEED_W-1:0]  lcg_next_s;
    logic [IDX_W-1:0]   cand_s;
    logic               cand_new_s;
    logic [CNT_W-1:0]   count_next_s;
    logic               place_done_s;
    logic               idx_in_grid_s;
    logic [3:0]         nearby_s;
    logic [SCORE_W-1:0] score_inc_s;
    logic               win_s;
    logic               start_ok_s;

    // Mines among the in-grid 8-neighbourhood; edges are clipped, columns never wrap.
    function automatic logic [3:0] count_nearby(input logic [CELLS-1:0] map,
                                                input logic [IDX_W-1:0] idx);
        int row;
        int col;
        int k;
        logic [3:0] n;
        row = int'(idx) / GRID_W;
        col = int'(idx) % GRID_W;
        n   = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                k = (row + dr) * GRID_W + col + dc;
                if ((dr != 0 || dc != 0) && (row + dr >= 0) && (row + dr < GRID_H) &&
                    (col + dc >= 0) && (col + dc < GRID_W)) begin
                    n = n + {3'd0, map[IDX_W'(k)]};
                end else begin
                    n = n;
                end
            end
        end
        return n;
    endfunction

    // Next LCG value, placement candidate and evaluation results for the captured index
    always_comb begin
        lcg_next_s    = in_mult * lcg_r + in_increment;
        cand_s        = IDX_W'(32'(lcg_next_s) % 32'(CELLS));
        cand_new_s    = ~out_mines[cand_s];
        count_next_s  = count_r + CNT_W'(cand_new_s);
        place_done_s  = (count_next_s == CNT_W'(N_MINES));
        idx_in_grid_s = ({1'b0, sel_idx_r} < (IDX_W + 1)'(CELLS));
        nearby_s      = count_nearby(out_mines, sel_idx_r);
        score_inc_s   = (&out_score) ? out_score : out_score + SCORE_W'(1);
        win_s         = (score_inc_s == SCORE_W'(CELLS - N_MINES));
        start_ok_s    = in_start && ((state_r == S_IDLE) || (state_r == S_WAIT) ||
                                     (state_r == S_OVER));
    end

    assign out_state = state_r;

    // Board state machine with all outputs registered
    always_ff @(posedge in_clka or negedge in_restart_n) begin
        if (!in_restart_n) begin
            state_r          <= S_IDLE;
            lcg_r            <= '0;
            count_r          <= '0;
            sel_idx_r        <= '0;
            out_sel_ready    <= 1'b0;
            out_mines        <= '0;
            out_cleared      <= '0;
            out_n_nearby     <= 4'd0;
            out_result_valid <= 1'b0;
            out_score        <= '0;
            out_gameover     <= 1'b0;
            out_win          <= 1'b0;
`ifdef FLAG_EN
            sel_flag_r       <= 1'b0;
            out_flags        <= '0;
`endif
        end else begin
            out_result_valid <= 1'b0;
            if (start_ok_s) begin
                // Start wins over a simultaneous selection in WAIT.
                state_r       <= S_PLACE;
                out_sel_ready <= 1'b0;
                lcg_r         <= in_seed;
                count_r       <= '0;
                out_mines     <= '0;
                out_cleared   <= '0;
                out_n_nearby  <= 4'd0;
                out_score     <= '0;
                out_gameover  <= 1'b0;
                out_win       <= 1'b0;
`ifdef FLAG_EN
                out_flags     <= '0;
`endif
            end else begin
                case (state_r)
                    S_PLACE: begin
                        lcg_r <= lcg_next_s;
                        if (cand_new_s) begin
                            out_mines[cand_s] <= 1'b1;
                            count_r           <= count_next_s;
                        end
                        if (place_done_s) begin
                            state_r       <= S_WAIT;
                            out_sel_ready <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (in_sel_valid) begin
                            sel_idx_r     <= in_sel_idx;
`ifdef FLAG_EN
                            sel_flag_r    <= in_sel_flag;
`endif
                            state_r       <= S_EVAL;
                            out_sel_ready <= 1'b0;
                        end
                    end
                    S_EVAL: begin
                        state_r       <= S_WAIT;
                        out_sel_ready <= 1'b1;
                        if (!idx_in_grid_s) begin
                            out_n_nearby <= out_n_nearby;
                        end
`ifdef FLAG_EN
                        else if (sel_flag_r) begin
                            if (!out_cleared[sel_idx_r]) begin
                                out_flags[sel_idx_r] <= ~out_flags[sel_idx_r];
                            end
                        end else if (out_flags[sel_idx_r]) begin
                            out_result_valid <= 1'b1;
                            out_n_nearby     <= 4'd0;
                        end
`endif
                        else if (out_cleared[sel_idx_r]) begin
                            out_result_valid <= 1'b1;
                            out_n_nearby     <= nearby_s;
                        end else if (out_mines[sel_idx_r]) begin
                            out_result_valid <= 1'b1;
                            out_n_nearby     <= 4'd0;
                            out_gameover     <= 1'b1;
                            state_r          <= S_OVER;
                            out_sel_ready    <= 1'b0;
                        end else begin
                            out_result_valid       <= 1'b1;
                            out_n_nearby           <= nearby_s;
                            out_cleared[sel_idx_r] <= 1'b1;
                            out_score              <= score_inc_s;
                            if (win_s) begin
                                out_win       <= 1'b1;
                                state_r       <= S_OVER;
                                out_sel_ready <= 1'b0;
                            end
                        end
                    end
                    S_IDLE, S_OVER: begin
                        state_r <= state_r;
                    end
                    default: begin
                        state_r       <= S_IDLE;
                        out_sel_ready <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
